// File: rtl/fetch_unit.sv
// fetch_unit: sequences fetch PCs to instruction memory and queues returned words for decode.
// Build option FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets and halt until an aligned one.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_4,
    output logic        misalign_err
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic             r_halt;
    logic             w_halt_nxt;
    entry_t           r_buf [BUF_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_pending;
    logic             w_misalign;
    logic [31:0]      w_redir_pc;
    entry_t           w_head;

    assign w_full    = (r_count == CNT_W'(BUF_DEPTH));
    assign imem_req  = (r_state == REQ) && !w_full;
    assign imem_addr = r_fetch_pc;
    assign id_valid  = (r_count != CNT_W'(0));
    assign w_pop     = id_valid && id_ready;

    // Head is forced to zero while empty so the reset view is clean without resetting storage.
    assign w_head   = r_buf[r_rptr];
    assign id_instr = id_valid ? w_head.instr : 32'h0;
    assign id_pc    = id_valid ? w_head.pc : 32'h0;
    assign id_pc_4  = id_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc   = redirect_pc;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end
`else
    assign w_misalign   = 1'b0;
    assign w_redir_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign misalign_err = 1'b0;
`endif

    // w_pending: a request is still in flight after this edge (must be drained on redirect).
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_halt_nxt     = r_halt;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        w_pending      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_halt) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_req) begin
                    w_pending = !imem_ack;
                    if (imem_ack) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_pending = !imem_ack;
                if (imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = REQ;
                end
            end
            DRAIN: begin
                w_pending = !imem_ack;
                if (imem_ack) begin
                    w_state_nxt = r_halt ? IDLE : REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (redirect_valid) begin
            w_flush        = 1'b1;
            w_push         = 1'b0;
            w_halt_nxt     = w_misalign;
            w_fetch_pc_nxt = w_redir_pc;
            if (w_pending) begin
                w_state_nxt = DRAIN;
            end else if (w_misalign) begin
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_halt     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_halt     <= w_halt_nxt;
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wptr] <= '{instr: imem_rdata, pc: r_fetch_pc};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic against an in-order PC stream model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH = 2;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready       = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_4;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_4        (id_pc_4),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Memory model: latency 0 acks in the request cycle, latency k acks k cycles later.
    logic        mem_pend   = 1'b0;
    int unsigned mem_cnt    = 0;
    logic [31:0] mem_addr_q = 32'h0;
    int unsigned lat_cfg    = 0;
    bit          lat_rand   = 1'b0;
    int unsigned lat_rnd_q  = 0;
    bit          keep_pend  = 1'b0;
    int unsigned lat_now;

    always_comb begin
        lat_now    = lat_rand ? lat_rnd_q : lat_cfg;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(mem_addr_q);
            end
        end else if (imem_req && lat_now == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end
    end

    always @(posedge clk) begin
        lat_rnd_q <= $urandom_range(0, 3);
        if (rst && !keep_pend) begin
            mem_pend <= 1'b0;
        end else if (mem_pend) begin
            if (mem_cnt == 0) mem_pend <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end else if (imem_req && !imem_ack) begin
            mem_pend   <= 1'b1;
            mem_cnt    <= lat_now - 1;
            mem_addr_q <= imem_addr;
        end
    end

    // Leaves the bench at the first negedge with rst low; the DUT is still in IDLE there.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b0;
        lat_rand = 1'b0; lat_cfg = 0; keep_pend = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b expected 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h expected 0", id_instr); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h expected 0", id_pc); else n_pass++;
        n_checks++; if (id_pc_4 !== 32'h4) $display("FAIL reset_id_pc_4: got %h expected 4", id_pc_4); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", misalign_err); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL first_addr: got %h expected %h", imem_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_startup();
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL startup_valid_early: got %b expected 0", id_valid); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL startup_valid[%0d]: got %b expected 1", k, id_valid); else n_pass++;
            n_checks++; if (id_pc !== RESET_PC + 32'(4 * k)) $display("FAIL startup_pc[%0d]: got %h expected %h", k, id_pc, RESET_PC + 32'(4 * k)); else n_pass++;
            n_checks++; if (id_instr !== mem_word(RESET_PC + 32'(4 * k))) $display("FAIL startup_instr[%0d]: got %h expected %h", k, id_instr, mem_word(RESET_PC + 32'(4 * k))); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        id_ready = 1'b1;
        exp_pc   = RESET_PC;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (id_pc !== exp_pc) $display("FAIL bp_pre_pc[%0d]: got %h expected %h", k, id_pc, exp_pc); else n_pass++;
            exp_pc += 32'd4;
            @(negedge clk);
        end
        id_ready = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_full_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (id_valid !== 1'b1) $display("FAIL bp_full_valid: got %b expected 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== exp_pc) $display("FAIL bp_full_head: got %h expected %h", id_pc, exp_pc); else n_pass++;
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (id_valid !== 1'b1) $display("FAIL bp_rel_valid[%0d]: got %b expected 1", k, id_valid); else n_pass++;
            n_checks++; if (id_pc !== exp_pc) $display("FAIL bp_rel_pc[%0d]: got %h expected %h", k, id_pc, exp_pc); else n_pass++;
            exp_pc += 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_wait();
        int k;
        do_reset();
        lat_cfg = 3;
        k = 0;
        do begin @(negedge clk); k++; end while (!imem_req && k < 20);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rw_flush_valid: got %b expected 0", id_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rw_drain_req: got %b expected 0", imem_req); else n_pass++;
        k = 0;
        while (!id_valid && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (id_valid !== 1'b1) $display("FAIL rw_timeout: got %b expected 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'h100) $display("FAIL rw_pc: got %h expected %h", id_pc, 32'h100); else n_pass++;
        n_checks++; if (id_instr !== mem_word(32'h100)) $display("FAIL rw_instr: got %h expected %h", id_instr, mem_word(32'h100)); else n_pass++;
        lat_cfg = 0;
    endtask

    task automatic test_redirect_ack_full();
        logic [31:0] tgt;
        int          k;
        tgt = 32'h0000_2468;
        do_reset();
        k = 0;
        do begin @(negedge clk); k++; end while (!(imem_req && imem_ack && id_valid) && k < 20);
        redirect_valid = 1'b1; redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL raf_flush_valid: got %b expected 0", id_valid); else n_pass++;
        n_checks++; if (imem_addr !== tgt) $display("FAIL raf_addr: got %h expected %h", imem_addr, tgt); else n_pass++;
        @(negedge clk);
        n_checks++; if (id_valid !== 1'b1) $display("FAIL raf_latency_valid: got %b expected 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== tgt) $display("FAIL raf_pc: got %h expected %h", id_pc, tgt); else n_pass++;
        n_checks++; if (id_instr !== mem_word(tgt)) $display("FAIL raf_instr: got %h expected %h", id_instr, mem_word(tgt)); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL wrap_flush_valid: got %b expected 0", id_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0: got %h expected FFFFFFFC", id_pc); else n_pass++;
        n_checks++; if (id_pc_4 !== 32'h0) $display("FAIL wrap_pc_4: got %h expected 0", id_pc_4); else n_pass++;
        id_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (id_pc !== 32'h0) $display("FAIL wrap_pc1: got %h expected 0", id_pc); else n_pass++;
        n_checks++; if (id_instr !== mem_word(32'h0)) $display("FAIL wrap_instr1: got %h expected %h", id_instr, mem_word(32'h0)); else n_pass++;
        id_ready = 1'b0;
    endtask

    task automatic test_drain_last_wins();
        int k;
        do_reset();
        lat_cfg = 4;
        k = 0;
        do begin @(negedge clk); k++; end while (!imem_req && k < 20);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        k = 0;
        while (!id_valid && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (id_valid !== 1'b1) $display("FAIL dlw_timeout: got %b expected 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'h500) $display("FAIL dlw_pc: got %h expected %h", id_pc, 32'h500); else n_pass++;
        lat_cfg = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        lat_cfg  = 1;
        id_ready = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!(imem_req && imem_addr == RESET_PC + 32'd4) && k < 20);
        rst = 1'b1; keep_pend = 1'b1; id_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; lat_cfg = 0;
        @(negedge clk);
        keep_pend = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rm_stale_valid: got %b expected 0", id_valid); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL rm_addr: got %h expected %h", imem_addr, RESET_PC); else n_pass++;
        @(negedge clk);
        n_checks++; if (id_pc !== RESET_PC) $display("FAIL rm_pc: got %h expected %h", id_pc, RESET_PC); else n_pass++;
        n_checks++; if (id_instr !== mem_word(RESET_PC)) $display("FAIL rm_instr: got %h expected %h", id_instr, mem_word(RESET_PC)); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL mis_flush_valid: got %b expected 0", id_valid); else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
        n_checks++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse: got %b expected 1", misalign_err); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (imem_req !== 1'b0) $display("FAIL mis_hold_req[%0d]: got %b expected 0", k, imem_req); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse_end: got %b expected 0", misalign_err); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (id_pc !== 32'h200) $display("FAIL mis_resume_pc: got %h expected %h", id_pc, 32'h200); else n_pass++;
`else
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL mis_err_off: got %b expected 0", misalign_err); else n_pass++;
        @(negedge clk);
        n_checks++; if (id_pc !== 32'h100) $display("FAIL mis_masked_pc: got %h expected %h", id_pc, 32'h100); else n_pass++;
`endif
    endtask

    // Model: decode must see consecutive PCs starting at reset PC, restarting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int          delivered;
        do_reset();
        lat_rand  = 1'b1;
        exp_pc    = RESET_PC;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                redirect_valid = 1'b1; redirect_pc = tgt; id_ready = 1'b0;
                exp_pc = tgt;
            end else begin
                redirect_valid = 1'b0;
                id_ready = ($urandom_range(0, 3) != 0);
                if (id_valid && id_ready) begin
                    n_checks++; if (id_pc !== exp_pc) $display("FAIL rnd_pc@%0d: got %h expected %h", c, id_pc, exp_pc); else n_pass++;
                    n_checks++; if (id_instr !== mem_word(exp_pc)) $display("FAIL rnd_instr@%0d: got %h expected %h", c, id_instr, mem_word(exp_pc)); else n_pass++;
                    n_checks++; if (id_pc_4 !== exp_pc + 32'd4) $display("FAIL rnd_pc_4@%0d: got %h expected %h", c, id_pc_4, exp_pc + 32'd4); else n_pass++;
                    exp_pc += 32'd4;
                    delivered++;
                end
            end
        end
        redirect_valid = 1'b0; id_ready = 1'b0; lat_rand = 1'b0;
        n_checks++; if (delivered < 200) $display("FAIL rnd_progress: got %0d expected at least 200", delivered); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_full();
        test_wrap();
        test_drain_last_wins();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
